// File: rtl/weight_pattern_gen_if.sv
// Handshake bundle between weight_pattern_gen (master) and its pattern sink (slave).
// Define WPG_PARITY_EN to add the registered parity output par.
interface weight_pattern_gen_if #(
   parameter int W = 9
);
   logic         start;
   logic [3:0]   K;
   logic         ready;
   logic [W-1:0] M;
   logic         valid;
   logic         busy;
   logic         done;
   logic         err;
   logic [7:0]   count;
`ifdef WPG_PARITY_EN
   logic         par;

   modport master (
      input  start, K, ready,
      output M, valid, busy, done, err, count, par
   );

   modport slave (
      output start, K, ready,
      input  M, valid, busy, done, err, count, par
   );
`else
   modport master (
      input  start, K, ready,
      output M, valid, busy, done, err, count
   );

   modport slave (
      output start, K, ready,
      input  M, valid, busy, done, err, count
   );
`endif
endinterface

// File: rtl/weight_pattern_gen.sv
// Enumerates every W-bit vector of popcount K in ascending order over a valid/ready handshake.
// Optional feature macro: WPG_PARITY_EN (adds registered parity output par on the interface).
module weight_pattern_gen #(
   parameter int W = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   weight_pattern_gen_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   localparam logic [W-1:0] ALL1 = '1;
   localparam logic [W-1:0] ONE  = W'(1);

   state_t       state_q, state_d;
   logic [W-1:0] m_q, m_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic [7:0]   count_q, count_d;
   logic [3:0]   k_q, k_d;
`ifdef WPG_PARITY_EN
   logic         par_q, par_d;
`endif

   logic         k_legal;
   logic [W-1:0] first_pat;
   logic [W-1:0] last_pat;
   logic [W-1:0] next_pat;
   int unsigned  low_pos;
   int unsigned  gap_pos;
   logic         seen_one;
   logic         seen_gap;

   // Last pattern is K ones packed at the top; a shift by W (K=0) yields all zeros.
   always_comb begin
      k_legal   = ({28'd0, bus.K} <= 32'(W));
      first_pat = ~(ALL1 << bus.K);
      last_pat  = ALL1 << (32'(W) - {28'd0, k_q});
   end

   // Next same-popcount value: move the top bit of the lowest run of ones up by one
   // and repack the remaining ones of that run at bit 0.
   always_comb begin
      low_pos  = 0;
      gap_pos  = W;
      seen_one = 1'b0;
      seen_gap = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (!seen_one && m_q[i]) begin
            seen_one = 1'b1;
            low_pos  = i;
         end else if (seen_one && !seen_gap && !m_q[i]) begin
            seen_gap = 1'b1;
            gap_pos  = i;
         end
      end
      next_pat = (m_q & (ALL1 << gap_pos)) | (ONE << gap_pos)
               | ~(ALL1 << (gap_pos - low_pos - 1));
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      count_d = count_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (k_legal) begin
                  state_d = RUN;
                  k_d     = bus.K;
                  m_d     = first_pat;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  count_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (valid_q && bus.ready) begin
               count_d = count_q + 8'd1;
               if (m_q == last_pat) begin
                  state_d = FIN;
                  m_d     = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  m_d = next_pat;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef WPG_PARITY_EN
      par_d = ^m_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
         k_q     <= '0;
`ifdef WPG_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         count_q <= count_d;
         k_q     <= k_d;
`ifdef WPG_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.M     = m_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.count = count_q;
`ifdef WPG_PARITY_EN
   assign bus.par   = par_q;
`endif

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Directed self-checking bench for weight_pattern_gen; expected sequences come from a
// brute-force ascending scan of all W-bit values with the requested popcount.
module tb_weight_pattern_gen;

   localparam int W = 9;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   weight_pattern_gen_if #(.W(W)) bus ();

   weight_pattern_gen #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Runs one full enumeration for k, holding ready low for 'stall' cycles on the first
   // pattern; returns the number of transfers observed.
   task automatic run_and_check(input int k, input int stall, output int n_seen);
      logic [W-1:0] v;
      logic [3:0]   kk;
      int           n_exp;
      int           idx;
      kk    = 4'(k);
      n_exp = 0;
      for (int i = 0; i < (1 << W); i++) begin
         v = W'(i);
         if ($countones(v) == k) n_exp++;
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.K     = kk;
      bus.ready = (stall == 0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.K     = 4'hF;
      idx = 0;
      for (int i = 0; i < (1 << W); i++) begin
         v = W'(i);
         if ($countones(v) != k) continue;
         total++;
         if (bus.valid !== 1'b1 || bus.M !== v) begin
            bad++;
            $display("FAIL pattern k=%0d idx=%0d: got valid=%b M=%h want valid=1 M=%h",
                     k, idx, bus.valid, bus.M, v);
         end
         total++;
         if (bus.count !== 8'(idx) || {bus.busy, bus.done, bus.err} !== 3'b100) begin
            bad++;
            $display("FAIL run_status k=%0d idx=%0d: got count=%0d bde=%b want count=%0d bde=100",
                     k, idx, bus.count, {bus.busy, bus.done, bus.err}, idx);
         end
`ifdef WPG_PARITY_EN
         total++;
         if (bus.par !== kk[0]) begin
            bad++;
            $display("FAIL parity k=%0d idx=%0d: got %b want %b", k, idx, bus.par, kk[0]);
         end
`endif
         if (idx == 0 && stall > 0) begin
            for (int s = 1; s < stall; s++) begin
               @(negedge clk);
               total++;
               if (bus.M !== v || bus.valid !== 1'b1 || bus.count !== 8'd0) begin
                  bad++;
                  $display("FAIL stall_hold k=%0d cyc=%0d: got M=%h valid=%b count=%0d want M=%h valid=1 count=0",
                           k, s, bus.M, bus.valid, bus.count, v);
               end
            end
            bus.ready = 1'b1;
         end
         bus.start = (idx == 1);
         @(negedge clk);
         idx++;
      end
      n_seen = idx;
      total++;
      if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0010 || bus.M !== '0
          || bus.count !== 8'(n_exp)) begin
         bad++;
         $display("FAIL fin k=%0d: got vbde=%b M=%h count=%0d want vbde=0010 M=000 count=%0d",
                  k, {bus.valid, bus.busy, bus.done, bus.err}, bus.M, bus.count, n_exp);
      end
`ifdef WPG_PARITY_EN
      total++;
      if (bus.par !== 1'b0) begin
         bad++;
         $display("FAIL parity_idle k=%0d: got %b want 0", k, bus.par);
      end
`endif
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.M !== '0
          || bus.count !== 8'(n_exp)) begin
         bad++;
         $display("FAIL after_fin k=%0d: got vbde=%b M=%h count=%0d want vbde=0000 M=000 count=%0d",
                  k, {bus.valid, bus.busy, bus.done, bus.err}, bus.M, bus.count, n_exp);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.K     = 4'd3;
      bus.ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.M !== '0
          || bus.count !== 8'd0) begin
         bad++;
         $display("FAIL reset_state: got vbde=%b M=%h count=%0d want vbde=0000 M=000 count=0",
                  {bus.valid, bus.busy, bus.done, bus.err}, bus.M, bus.count);
      end
      bus.start = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      total++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got valid=%b busy=%b want 0 0", bus.valid, bus.busy);
      end
   endtask

   task automatic test_all_ones();
      int n;
      run_and_check(9, 0, n);
      total++;
      if (n !== 1 || bus.count !== 8'd1) begin
         bad++;
         $display("FAIL all_ones: got transfers=%0d count=%0d want 1 1", n, bus.count);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] bad_k [2];
      bad_k[0] = 4'd10;
      bad_k[1] = 4'd15;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.K     = bad_k[j];
         @(negedge clk);
         bus.start = 1'b0;
         total++;
         if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0001 || bus.count !== 8'd1) begin
            bad++;
            $display("FAIL illegal_err K=%0d: got vbde=%b count=%0d want vbde=0001 count=1",
                     bad_k[j], {bus.valid, bus.busy, bus.done, bus.err}, bus.count);
         end
         @(negedge clk);
         total++;
         if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.M !== '0) begin
            bad++;
            $display("FAIL illegal_after K=%0d: got vbde=%b M=%h want vbde=0000 M=000",
                     bad_k[j], {bus.valid, bus.busy, bus.done, bus.err}, bus.M);
         end
      end
   endtask

   task automatic test_k2();
      logic [W-1:0] head [4];
      int           n;
      head[0] = 9'h003;
      head[1] = 9'h005;
      head[2] = 9'h006;
      head[3] = 9'h009;
      @(negedge clk);
      bus.start = 1'b1;
      bus.K     = 4'd2;
      bus.ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (bus.M !== head[j] || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL k2_head idx=%0d: got M=%h valid=%b want M=%h valid=1",
                     j, bus.M, bus.valid, head[j]);
         end
         @(negedge clk);
      end
      repeat (31) @(negedge clk);
      total++;
      if (bus.M !== 9'h180 || bus.valid !== 1'b1 || bus.count !== 8'd35) begin
         bad++;
         $display("FAIL k2_last: got M=%h valid=%b count=%0d want M=180 valid=1 count=35",
                  bus.M, bus.valid, bus.count);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.count !== 8'd36) begin
         bad++;
         $display("FAIL k2_done: got done=%b valid=%b count=%0d want done=1 valid=0 count=36",
                  bus.done, bus.valid, bus.count);
      end
      @(negedge clk);
      run_and_check(2, 0, n);
      total++;
      if (n !== 36) begin
         bad++;
         $display("FAIL k2_transfers: got %0d want 36", n);
      end
   endtask

   task automatic test_k0();
      int n;
      run_and_check(0, 0, n);
      total++;
      if (n !== 1 || bus.count !== 8'd1) begin
         bad++;
         $display("FAIL k0: got transfers=%0d count=%0d want 1 1", n, bus.count);
      end
   endtask

   task automatic test_backpressure();
      int n;
      run_and_check(4, 3, n);
      total++;
      if (n !== 126 || bus.count !== 8'd126) begin
         bad++;
         $display("FAIL backpressure: got transfers=%0d count=%0d want 126 126", n, bus.count);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.K     = 4'd3;
      bus.ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if (bus.M !== 9'h007) begin
         bad++;
         $display("FAIL midrun_first: got %h want 007", bus.M);
      end
      repeat (10) @(negedge clk);
      total++;
      if (bus.count !== 8'd10 || bus.valid !== 1'b1) begin
         bad++;
         $display("FAIL midrun_count: got count=%0d valid=%b want 10 1", bus.count, bus.valid);
      end
      reset     = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      total++;
      if ({bus.valid, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.M !== '0
          || bus.count !== 8'd0) begin
         bad++;
         $display("FAIL midrun_reset: got vbde=%b M=%h count=%0d want vbde=0000 M=000 count=0",
                  {bus.valid, bus.busy, bus.done, bus.err}, bus.M, bus.count);
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (bus.done !== 1'b0 || bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL midrun_nodone: got done=%b valid=%b want 0 0", bus.done, bus.valid);
         end
      end
      run_and_check(3, 0, n);
      total++;
      if (n !== 84) begin
         bad++;
         $display("FAIL midrun_restart: got transfers=%0d want 84", n);
      end
   endtask

   task automatic test_all_k();
      int n;
      int binom [10];
      binom = '{1, 9, 36, 84, 126, 126, 84, 36, 9, 1};
      for (int k = 0; k <= 9; k++) begin
         run_and_check(k, 0, n);
         total++;
         if (n !== binom[k]) begin
            bad++;
            $display("FAIL all_k k=%0d: got transfers=%0d want %0d", k, n, binom[k]);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.K     = 4'd0;
      bus.ready = 1'b0;
      reset     = 1'b1;
      test_reset();
      test_all_ones();
      test_illegal();
      test_k2();
      test_k0();
      test_backpressure();
      test_reset_mid_run();
      test_all_k();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/weight_pattern_gen.md
WEIGHT_PATTERN_GEN -- requirements
Module: weight_pattern_gen

Interface
REQ-001 The block SHALL have parameter W, default 9, meaning pattern width in bits; the supported range is 4..9.
REQ-002 Port clk SHALL be an input of width 1 and is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be an input of width 1; reset is synchronous and active-high.
REQ-004 Port start SHALL be an input of width 1 that requests a new enumeration run.
REQ-005 Port K SHALL be an input of width 4 giving the target number of logic-high bits.
REQ-006 Port ready SHALL be an input of width 1 through which the sink accepts the current pattern.
REQ-007 Port M SHALL be an output of width W carrying the current pattern.
REQ-008 Port valid SHALL be an output of width 1 indicating that M holds a pattern.
REQ-009 Port busy SHALL be an output of width 1, high from run start through the final handshake.
REQ-010 Port done SHALL be an output of width 1 that pulses for one cycle at run end.
REQ-011 Port err SHALL be an output of width 1 that pulses for one cycle when the requested K is illegal.
REQ-012 Port count SHALL be an output of width 8 giving the number of patterns accepted in the current or last run.

Function
REQ-013 The block SHALL emit, in ascending numeric order, every W-bit vector whose popcount equals K, each exactly once.
REQ-014 The FSM SHALL have states IDLE, RUN and FIN.
REQ-015 IDLE SHALL transition to RUN on start=1 with K<=W, and SHALL sample K on that edge; later changes to K SHALL be ignored until the next run.
REQ-016 The first pattern SHALL be (2^K)-1, presented with valid=1 in the cycle after start is sampled (one-cycle latency).
REQ-017 In IDLE, start=1 with K>W SHALL pulse err for one cycle, SHALL leave valid low and count unchanged, and SHALL remain in IDLE.
REQ-018 A transfer SHALL occur only in a cycle with valid=1 and ready=1.
REQ-019 While valid=1 and ready=0, M SHALL hold stable.
REQ-020 On each transfer, count SHALL increment and M SHALL advance to the next larger integer with the same popcount, with no idle cycle between patterns.
REQ-021 The transfer of the final pattern (K ones in the top K bit positions, or 0 when K=0) SHALL move the FSM to FIN and drop valid on the next cycle.
REQ-022 FIN SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-023 K=0 SHALL produce exactly one pattern, 0.
REQ-024 K=W SHALL produce exactly one pattern, all ones.
REQ-025 start asserted in RUN or FIN SHALL be ignored.
REQ-026 count SHALL hold its final value (C(W,K)) after done and SHALL clear to 0 on the next accepted start.
REQ-027 M SHALL be 0 whenever valid=0.

Reset
REQ-028 reset=1 SHALL force state=IDLE, M=0, valid=0, busy=0, done=0, err=0 and count=0 on the next clk edge, in every state.
REQ-029 reset SHALL take priority over start, ready and any in-flight transfer.
REQ-030 A run aborted by reset SHALL NOT produce done.

Configuration
REQ-031 With macro WPG_PARITY_EN defined, the block SHALL add a 1-bit output port par equal to the XOR of all bits of M, registered alongside M, reset to 0, and equal to K[0] while valid=1.
REQ-032 Without WPG_PARITY_EN, the par port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 Scenario single all-ones pattern: K=9, start pulse, ready=1 -> one transfer of M=0x1FF; then done pulse; count=1.
REQ-034 Scenario K=2 enumeration: K=2, ready=1 -> patterns 0x003, 0x005, 0x006, 0x009 ... 0x180, 36 transfers; count=36; done one cycle after the 0x180 transfer.
REQ-035 Scenario K=0 and illegal K: K=0 -> single transfer of M=0x000 and done. K=10 -> err pulse, valid never high, busy never high.
REQ-036 Scenario backpressure: K=4, ready held low 3 cycles on the first pattern -> M=0x00F stable for 3 cycles; total transfers=126; no pattern lost or duplicated.
REQ-037 Scenario reset mid-run: reset asserted after 10 transfers with K=3 -> next cycle all outputs 0, no done; a fresh start then restarts from 0x007.
REQ-038 Scenario WPG_PARITY_EN defined: par=K[0] on every valid cycle for K=0..9.
